rob_commit: RTL and testbench

In-order retirement engine at the extract end of the reorder buffer. Each cycle it inspects up to EXT_COUNT head slots and tells the ROB how many to consume. It retires completed entries to the register file and the store port, and turns the oldest excepting entry into a pipeline flush. It sits between the ROB, the register file write ports, the store buffer and the fetch redirect logic.

---
 rtl/rob_pkg.sv | 27 ++
 rtl/rob_commit_if.sv | 43 ++++
 rtl/rob_commit_select.sv | 74 +++++++
 rtl/rob_commit.sv | 117 +++++++++++
 tb/tb_rob_commit.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/rob_pkg.sv
// Shared types and defaults for the ROB retirement engine.
//   rob_entry_t    : one ROB entry as seen at the extract end
//   commit_state_t : retirement FSM states
//   ROB_DEPTH / ROB_EXT_COUNT : default ROB size and head-slot count
package rob_pkg;

  localparam int unsigned ROB_DEPTH     = 16;
  localparam int unsigned ROB_EXT_COUNT = 2;

  typedef struct packed {
    logic [4:0]  dest;
    logic        wr_en;
    logic [31:0] result;
    logic        is_store;
    logic [31:0] st_data;
    logic        exception;
    logic [4:0]  cause;
    logic [31:0] pc;
  } rob_entry_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } commit_state_t;

endpackage

// File: rtl/rob_commit_if.sv
// Bundle between the ROB/register file/store buffer side and rob_commit.
//   slave  : the retirement engine (consumes ROB head, drives retire outputs)
//   master : the surrounding pipeline (drives ROB head, store-buffer ready)
interface rob_commit_if
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH     = ROB_DEPTH,
  parameter int unsigned EXT_COUNT = ROB_EXT_COUNT
);
  localparam int unsigned DEPTHLOG2 = $clog2(DEPTH);
  localparam int unsigned CNTW      = $clog2(EXT_COUNT + 1);

  rob_entry_t [EXT_COUNT-1:0]       slot_data;
  logic [EXT_COUNT-1:0]             slot_valid;
  logic [DEPTHLOG2-1:0]             used_count;
  logic                             rob_empty;
  logic [CNTW-1:0]                  consume_count;
  logic [EXT_COUNT-1:0]             rf_we;
  logic [EXT_COUNT-1:0][4:0]        rf_waddr;
  logic [EXT_COUNT-1:0][31:0]       rf_wdata;
  logic                             st_valid;
  logic                             st_ready;
  logic [31:0]                      st_addr;
  logic [31:0]                      st_data;
  logic                             flush;
  logic                             exc_valid;
  logic [31:0]                      exc_pc;
  logic [4:0]                       exc_cause;
  logic [31:0]                      retired_count;

  modport slave (
    input  slot_data, slot_valid, used_count, rob_empty, st_ready,
    output consume_count, rf_we, rf_waddr, rf_wdata, st_valid, st_addr,
           st_data, flush, exc_valid, exc_pc, exc_cause, retired_count
  );

  modport master (
    output slot_data, slot_valid, used_count, rob_empty, st_ready,
    input  consume_count, rf_we, rf_waddr, rf_wdata, st_valid, st_addr,
           st_data, flush, exc_valid, exc_pc, exc_cause, retired_count
  );

endinterface

// File: rtl/rob_commit_select.sv
// Combinational in-order prefix scan over the ROB head slots.
//   i_en          : scan allowed (RUN state, not in reset)
//   i_slot_data   : head entries, index 0 oldest
//   i_slot_valid  : entry completed
//   i_used_count  : occupied ROB slots
//   i_rob_empty   : ROB empty
//   i_st_ready    : store buffer ready
//   o_consume     : number of slots retiring this cycle
//   o_st_valid    : a store lies inside the retire window
//   o_st_idx      : slot index of that store
//   o_exc_flag    : scan stopped on a valid, in-range excepting slot
//   o_exc_idx     : slot index of that excepting entry
module rob_commit_select
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH     = ROB_DEPTH,
  parameter int unsigned EXT_COUNT = ROB_EXT_COUNT
)(
  input  logic                                   i_en,
  input  rob_entry_t [EXT_COUNT-1:0]             i_slot_data,
  input  logic [EXT_COUNT-1:0]                   i_slot_valid,
  input  logic [$clog2(DEPTH)-1:0]               i_used_count,
  input  logic                                   i_rob_empty,
  input  logic                                   i_st_ready,
  output logic [$clog2(EXT_COUNT+1)-1:0]         o_consume,
  output logic                                   o_st_valid,
  output logic [(EXT_COUNT>1 ? $clog2(EXT_COUNT) : 1)-1:0] o_st_idx,
  output logic                                   o_exc_flag,
  output logic [(EXT_COUNT>1 ? $clog2(EXT_COUNT) : 1)-1:0] o_exc_idx
);
  localparam int unsigned CNTW = $clog2(EXT_COUNT + 1);
  localparam int unsigned IDXW = (EXT_COUNT > 1) ? $clog2(EXT_COUNT) : 1;

  logic        w_stop;
  logic        w_store_seen;
  int unsigned w_cnt;

  always_comb begin
    w_stop       = 1'b0;
    w_store_seen = 1'b0;
    w_cnt        = 0;
    o_st_valid   = 1'b0;
    o_st_idx     = '0;
    o_exc_flag   = 1'b0;
    o_exc_idx    = '0;
    for (int unsigned i = 0; i < EXT_COUNT; i++) begin
      if (!w_stop) begin
        if (!i_en || i_rob_empty || i >= 32'(i_used_count) || !i_slot_valid[i]) begin
          w_stop = 1'b1;
        end else if (i_slot_data[i].exception) begin
          w_stop     = 1'b1;
          o_exc_flag = 1'b1;
          o_exc_idx  = IDXW'(i);
        end else if (i_slot_data[i].is_store) begin
          // Only one store port: a second store ends the window, and the
          // first one is offered even when it cannot retire yet.
          if (w_store_seen) begin
            w_stop = 1'b1;
          end else begin
            w_store_seen = 1'b1;
            o_st_valid   = 1'b1;
            o_st_idx     = IDXW'(i);
            if (i_st_ready) w_cnt = w_cnt + 1;
            else            w_stop = 1'b1;
          end
        end else begin
          w_cnt = w_cnt + 1;
        end
      end
    end
    o_consume = CNTW'(w_cnt);
  end

endmodule

// File: rtl/rob_commit.sv
// In-order retirement engine at the ROB extract end.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : rob_commit_if.slave - ROB head slots in; consume count,
//           register-file writes, store port, flush/exception report and
//           retired-instruction counter out.
module rob_commit
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH     = ROB_DEPTH,
  parameter int unsigned EXT_COUNT = ROB_EXT_COUNT
)(
  input  logic         clock,
  input  logic         reset,
  rob_commit_if.slave  bus
);
  localparam int unsigned CNTW = $clog2(EXT_COUNT + 1);
  localparam int unsigned IDXW = (EXT_COUNT > 1) ? $clog2(EXT_COUNT) : 1;

  commit_state_t              r_state;
  commit_state_t              w_state_nxt;
  logic                       w_en;
  logic [CNTW-1:0]            w_consume;
  logic                       w_st_valid;
  logic [IDXW-1:0]            w_st_idx;
  logic                       w_exc_flag;
  logic [IDXW-1:0]            w_exc_idx;

  logic [EXT_COUNT-1:0]       r_rf_we;
  logic [EXT_COUNT-1:0][4:0]  r_rf_waddr;
  logic [EXT_COUNT-1:0][31:0] r_rf_wdata;
  logic                       r_flush;
  logic                       r_exc_valid;
  logic [31:0]                r_exc_pc;
  logic [4:0]                 r_exc_cause;
  logic [31:0]                r_retired;

  // Gating with reset keeps consume_count at 0 while reset is held.
  assign w_en = (r_state == RUN) && !reset;

  rob_commit_select #(
    .DEPTH     (DEPTH),
    .EXT_COUNT (EXT_COUNT)
  ) u_select (
    .i_en         (w_en),
    .i_slot_data  (bus.slot_data),
    .i_slot_valid (bus.slot_valid),
    .i_used_count (bus.used_count),
    .i_rob_empty  (bus.rob_empty),
    .i_st_ready   (bus.st_ready),
    .o_consume    (w_consume),
    .o_st_valid   (w_st_valid),
    .o_st_idx     (w_st_idx),
    .o_exc_flag   (w_exc_flag),
    .o_exc_idx    (w_exc_idx)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RUN:     if (w_exc_flag)    w_state_nxt = FLUSH;
      FLUSH:                      w_state_nxt = DRAIN;
      DRAIN:   if (bus.rob_empty) w_state_nxt = RUN;
      default:                    w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rf_we     <= '0;
      r_rf_waddr  <= '0;
      r_rf_wdata  <= '0;
      r_flush     <= 1'b0;
      r_exc_valid <= 1'b0;
      r_exc_pc    <= '0;
      r_exc_cause <= '0;
      r_retired   <= '0;
    end else begin
      for (int unsigned k = 0; k < EXT_COUNT; k++) begin
        if (k < 32'(w_consume) && bus.slot_data[k].wr_en &&
            bus.slot_data[k].dest != '0) begin
          r_rf_we[k]    <= 1'b1;
          r_rf_waddr[k] <= bus.slot_data[k].dest;
          r_rf_wdata[k] <= bus.slot_data[k].result;
        end else begin
          r_rf_we[k]    <= 1'b0;
        end
      end
      r_flush     <= w_exc_flag;
      r_exc_valid <= w_exc_flag;
      if (w_exc_flag) begin
        r_exc_pc    <= bus.slot_data[w_exc_idx].pc;
        r_exc_cause <= bus.slot_data[w_exc_idx].cause;
      end
      r_retired <= r_retired + 32'(w_consume);
    end
  end

  assign bus.consume_count = w_consume;
  assign bus.st_valid      = w_st_valid;
  assign bus.st_addr       = bus.slot_data[w_st_idx].result;
  assign bus.st_data       = bus.slot_data[w_st_idx].st_data;
  assign bus.rf_we         = r_rf_we;
  assign bus.rf_waddr      = r_rf_waddr;
  assign bus.rf_wdata      = r_rf_wdata;
  assign bus.flush         = r_flush;
  assign bus.exc_valid     = r_exc_valid;
  assign bus.exc_pc        = r_exc_pc;
  assign bus.exc_cause     = r_exc_cause;
  assign bus.retired_count = r_retired;

endmodule

// File: tb/tb_rob_commit.sv
module tb_rob_commit;
  import rob_pkg::*;

  logic clock;
  logic reset;
  int unsigned n_checks;
  int unsigned n_fail;

  rob_commit_if #(.DEPTH(16), .EXT_COUNT(2)) bus ();

  rob_commit #(.DEPTH(16), .EXT_COUNT(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic rob_entry_t mk(input logic [4:0] dest, input logic wr_en,
                                    input logic [31:0] result, input logic is_store,
                                    input logic [31:0] st_data, input logic exc,
                                    input logic [4:0] cause, input logic [31:0] pc);
    rob_entry_t e;
    e.dest = dest; e.wr_en = wr_en; e.result = result; e.is_store = is_store;
    e.st_data = st_data; e.exception = exc; e.cause = cause; e.pc = pc;
    return e;
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rob_entry_t st0, st1;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.slot_data[0] = mk(5'd3, 1'b1, 32'h11, 1'b0, '0, 1'b0, '0, 32'h100);
    bus.slot_data[1] = mk(5'd4, 1'b1, 32'h22, 1'b0, '0, 1'b0, '0, 32'h104);
    bus.slot_valid   = 2'b11;
    bus.used_count   = 4'd5;
    bus.rob_empty    = 1'b0;
    bus.st_ready     = 1'b0;

    // Reset state
    #2;
    check_eq("rst_consume", 32'(bus.consume_count), 32'd0);
    check_eq("rst_rf_we",   32'(bus.rf_we),         32'd0);
    check_eq("rst_flush",   32'(bus.flush),         32'd0);
    check_eq("rst_exc",     32'(bus.exc_valid),     32'd0);
    check_eq("rst_retired", bus.retired_count,      32'd0);
    check_eq("rst_exc_pc",  bus.exc_pc,             32'd0);
    @(negedge clock);
    reset = 1'b0;
    settle();

    // Two plain retirements
    check_eq("t1_consume", 32'(bus.consume_count), 32'd2);
    step();
    bus.slot_valid = 2'b00;
    check_eq("t1_rf_we",    32'(bus.rf_we),       32'b11);
    check_eq("t1_waddr0",   32'(bus.rf_waddr[0]), 32'd3);
    check_eq("t1_waddr1",   32'(bus.rf_waddr[1]), 32'd4);
    check_eq("t1_wdata0",   bus.rf_wdata[0],      32'h11);
    check_eq("t1_wdata1",   bus.rf_wdata[1],      32'h22);
    check_eq("t1_retired",  bus.retired_count,    32'd2);

    // In-order stall
    bus.slot_valid = 2'b01;
    settle();
    check_eq("t2_consume_10", 32'(bus.consume_count), 32'd1);
    step();
    check_eq("t2_rf_we",   32'(bus.rf_we),    32'b01);
    check_eq("t2_retired", bus.retired_count, 32'd3);
    bus.slot_valid = 2'b10;
    settle();
    check_eq("t2_consume_01", 32'(bus.consume_count), 32'd0);
    step();
    check_eq("t2_rf_we_idle", 32'(bus.rf_we),    32'b00);
    check_eq("t2_retired2",   bus.retired_count, 32'd3);

    // Store back-pressure
    bus.slot_data[0] = mk(5'd0, 1'b0, 32'h1000, 1'b1, 32'hDEAD, 1'b0, '0, 32'h200);
    bus.slot_valid   = 2'b01;
    bus.st_ready     = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      check_eq("t3_st_valid", 32'(bus.st_valid),      32'd1);
      check_eq("t3_consume0", 32'(bus.consume_count), 32'd0);
      check_eq("t3_st_addr",  bus.st_addr,            32'h1000);
      check_eq("t3_st_data",  bus.st_data,            32'hDEAD);
      step();
    end
    bus.st_ready = 1'b1;
    settle();
    check_eq("t3_st_valid_rdy", 32'(bus.st_valid),      32'd1);
    check_eq("t3_consume1",     32'(bus.consume_count), 32'd1);
    check_eq("t3_st_addr_rdy",  bus.st_addr,            32'h1000);
    step();
    bus.slot_valid = 2'b00;
    check_eq("t3_rf_we",   32'(bus.rf_we),    32'b00);
    check_eq("t3_retired", bus.retired_count, 32'd4);

    // Exception in slot 1
    bus.slot_data[0] = mk(5'd5, 1'b1, 32'h55, 1'b0, '0, 1'b0, '0, 32'h3FC);
    bus.slot_data[1] = mk(5'd6, 1'b1, 32'h66, 1'b0, '0, 1'b1, 5'd4, 32'h400);
    bus.slot_valid   = 2'b11;
    settle();
    check_eq("t4_consume", 32'(bus.consume_count), 32'd1);
    check_eq("t4_noflush", 32'(bus.flush),         32'd0);
    step();
    check_eq("t4_flush",     32'(bus.flush),       32'd1);
    check_eq("t4_exc_valid", 32'(bus.exc_valid),   32'd1);
    check_eq("t4_exc_pc",    bus.exc_pc,           32'h400);
    check_eq("t4_exc_cause", 32'(bus.exc_cause),   32'd4);
    check_eq("t4_rf_we",     32'(bus.rf_we),       32'b01);
    check_eq("t4_waddr0",    32'(bus.rf_waddr[0]), 32'd5);
    check_eq("t4_retired",   bus.retired_count,    32'd5);
    // FLUSH: nothing retires even though the head still looks valid
    bus.slot_data[1] = mk(5'd6, 1'b1, 32'h66, 1'b1, 32'h77, 1'b0, '0, 32'h400);
    settle();
    check_eq("t4_flush_consume", 32'(bus.consume_count), 32'd0);
    check_eq("t4_flush_stv",     32'(bus.st_valid),      32'd0);
    step();
    check_eq("t4_flush_pulse", 32'(bus.flush),     32'd0);
    check_eq("t4_exc_pulse",   32'(bus.exc_valid), 32'd0);
    check_eq("t4_exc_pc_hold", bus.exc_pc,         32'h400);
    // DRAIN
    check_eq("t4_drain_consume", 32'(bus.consume_count), 32'd0);
    step();
    check_eq("t4_drain_consume2", 32'(bus.consume_count), 32'd0);
    bus.rob_empty = 1'b1;
    settle();
    check_eq("t4_drain_empty", 32'(bus.consume_count), 32'd0);
    step();
    bus.rob_empty    = 1'b0;
    bus.slot_data[0] = mk(5'd7, 1'b1, 32'h77, 1'b0, '0, 1'b0, '0, 32'h500);
    bus.slot_valid   = 2'b01;
    bus.used_count   = 4'd1;
    settle();
    check_eq("t4_run_again", 32'(bus.consume_count), 32'd1);
    step();
    check_eq("t4_retired2", bus.retired_count, 32'd6);

    // Two stores: one per cycle
    st0 = mk(5'd0, 1'b0, 32'hA000, 1'b1, 32'h1111, 1'b0, '0, 32'h600);
    st1 = mk(5'd0, 1'b0, 32'hB000, 1'b1, 32'h2222, 1'b0, '0, 32'h604);
    bus.slot_data[0] = st0;
    bus.slot_data[1] = st1;
    bus.slot_valid   = 2'b11;
    bus.used_count   = 4'd2;
    bus.st_ready     = 1'b1;
    settle();
    check_eq("t5_consume_a", 32'(bus.consume_count), 32'd1);
    check_eq("t5_st_addr_a", bus.st_addr,            32'hA000);
    step();
    bus.slot_data[0] = st1;
    bus.slot_valid   = 2'b01;
    bus.used_count   = 4'd1;
    settle();
    check_eq("t5_consume_b", 32'(bus.consume_count), 32'd1);
    check_eq("t5_st_data_b", bus.st_data,            32'h2222);
    step();
    check_eq("t5_retired", bus.retired_count, 32'd8);

    // Boundaries: used_count limits, empty ROB, dest 0, same dest
    bus.slot_data[0] = mk(5'd0, 1'b1, 32'h99, 1'b0, '0, 1'b0, '0, 32'h700);
    bus.slot_data[1] = mk(5'd9, 1'b1, 32'hAA, 1'b0, '0, 1'b0, '0, 32'h704);
    bus.slot_valid   = 2'b11;
    bus.used_count   = 4'd0;
    settle();
    check_eq("b_used0", 32'(bus.consume_count), 32'd0);
    bus.used_count = 4'd2;
    bus.rob_empty  = 1'b1;
    settle();
    check_eq("b_empty", 32'(bus.consume_count), 32'd0);
    bus.rob_empty  = 1'b0;
    bus.used_count = 4'd1;
    settle();
    check_eq("b_used1", 32'(bus.consume_count), 32'd1);
    step();
    check_eq("b_dest0_we", 32'(bus.rf_we), 32'b00);
    bus.slot_data[0] = mk(5'd9, 1'b1, 32'hB1, 1'b0, '0, 1'b0, '0, 32'h708);
    bus.slot_data[1] = mk(5'd9, 1'b1, 32'hB2, 1'b0, '0, 1'b0, '0, 32'h70C);
    bus.used_count   = 4'd2;
    step();
    check_eq("b_same_we",     32'(bus.rf_we),  32'b11);
    check_eq("b_same_wdata1", bus.rf_wdata[1], 32'hB2);
    check_eq("b_retired",     bus.retired_count, 32'd11);

    // Reset while draining
    bus.slot_data[0] = mk(5'd1, 1'b1, 32'h1, 1'b0, '0, 1'b1, 5'd2, 32'h800);
    bus.slot_valid   = 2'b01;
    settle();
    check_eq("r_exc_consume", 32'(bus.consume_count), 32'd0);
    step();
    check_eq("r_flush", 32'(bus.flush), 32'd1);
    step();
    bus.slot_data[0] = mk(5'd1, 1'b1, 32'h1, 1'b0, '0, 1'b0, '0, 32'h800);
    step();
    check_eq("r_drain_consume", 32'(bus.consume_count), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check_eq("r_rst_flush",   32'(bus.flush),         32'd0);
    check_eq("r_rst_rf_we",   32'(bus.rf_we),         32'd0);
    check_eq("r_rst_retired", bus.retired_count,      32'd0);
    check_eq("r_rst_consume", 32'(bus.consume_count), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    settle();
    check_eq("r_run_consume", 32'(bus.consume_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
